// File: rtl/inv_mixcolumns_iter_if.sv
// inv_mixcolumns_iter_if: valid/ready state bus between the column engine and its neighbours
// Ports: i_valid/o_ready/i_state (upstream side), o_valid/i_ready/o_state (downstream side),
// plus i_fwd_mode when INV_MIXCOLUMNS_FWD_MODE_EN is defined.
// slave = the engine, master = the block driving it.
interface inv_mixcolumns_iter_if #(
  parameter int NB_STATE = 128
);
  logic                i_valid;
  logic                o_ready;
  logic [NB_STATE-1:0] i_state;
  logic                o_valid;
  logic                i_ready;
  logic [NB_STATE-1:0] o_state;
`ifdef INV_MIXCOLUMNS_FWD_MODE_EN
  logic                i_fwd_mode;
  modport slave  (input  i_valid, i_state, i_ready, i_fwd_mode, output o_ready, o_valid, o_state);
  modport master (output i_valid, i_state, i_ready, i_fwd_mode, input  o_ready, o_valid, o_state);
`else
  modport slave  (input  i_valid, i_state, i_ready, output o_ready, o_valid, o_state);
  modport master (output i_valid, i_state, i_ready, input  o_ready, o_valid, o_state);
`endif
endinterface

// File: rtl/inv_mixcolumns_iter.sv
// inv_mixcolumns_iter: iterative AES InvMixColumns, one 32-bit column per clock
// Ports: i_clock, i_reset (sync, active-high), bus_if (slave side of inv_mixcolumns_iter_if).
// Optional macro INV_MIXCOLUMNS_FWD_MODE_EN adds i_fwd_mode selecting forward MixColumns.
module inv_mixcolumns_iter #(
  parameter int NB_BYTE  = 8,
  parameter int NB_STATE = 128
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  inv_mixcolumns_iter_if.slave  bus_if
);
  localparam int NB_COL = 4 * NB_BYTE;
  if (NB_BYTE != 8 || NB_STATE != 16 * NB_BYTE) begin : BAD_CONF
    $error("inv_mixcolumns_iter: NB_BYTE must be 8 and NB_STATE 16*NB_BYTE");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t              state_q, state_d;
  logic [1:0]          col_q, col_d;
  logic [NB_STATE-1:0] work_q, work_d;
  logic [NB_COL-1:0]   col_in, col_out;
  logic [NB_BYTE-1:0]  a [4];
  logic [NB_BYTE-1:0]  x2 [4];
  logic [NB_BYTE-1:0]  x4 [4];
  logic [NB_BYTE-1:0]  x8 [4];
  logic [NB_BYTE-1:0]  r_inv [4];
`ifdef INV_MIXCOLUMNS_FWD_MODE_EN
  logic                mode_q, mode_d;
  logic [NB_BYTE-1:0]  r_fwd [4];
`endif
  function automatic logic [NB_BYTE-1:0] xtime(input logic [NB_BYTE-1:0] b);
    return {b[NB_BYTE-2:0], 1'b0} ^ (b[NB_BYTE-1] ? NB_BYTE'(8'h1b) : '0);
  endfunction
  // single column datapath, fed from whichever column col_q points at
  assign col_in = work_q[NB_STATE-1-NB_COL*int'(col_q) -: NB_COL];
  genvar k;
  for (k = 0; k < 4; k++) begin : g_byte
    assign a[k]  = col_in[NB_COL-1-NB_BYTE*k -: NB_BYTE];
    assign x2[k] = xtime(a[k]);
    assign x4[k] = xtime(x2[k]);
    assign x8[k] = xtime(x4[k]);
    // row k: 0e*a[k] ^ 0b*a[k+1] ^ 0d*a[k+2] ^ 09*a[k+3]
    assign r_inv[k] = (x8[k] ^ x4[k] ^ x2[k])
                    ^ (x8[(k+1)%4] ^ x2[(k+1)%4] ^ a[(k+1)%4])
                    ^ (x8[(k+2)%4] ^ x4[(k+2)%4] ^ a[(k+2)%4])
                    ^ (x8[(k+3)%4] ^ a[(k+3)%4]);
`ifdef INV_MIXCOLUMNS_FWD_MODE_EN
    // row k: 02*a[k] ^ 03*a[k+1] ^ a[k+2] ^ a[k+3]
    assign r_fwd[k] = x2[k] ^ x2[(k+1)%4] ^ a[(k+1)%4] ^ a[(k+2)%4] ^ a[(k+3)%4];
    assign col_out[NB_COL-1-NB_BYTE*k -: NB_BYTE] = mode_q ? r_fwd[k] : r_inv[k];
`else
    assign col_out[NB_COL-1-NB_BYTE*k -: NB_BYTE] = r_inv[k];
`endif
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
`ifdef INV_MIXCOLUMNS_FWD_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
`ifdef INV_MIXCOLUMNS_FWD_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
`ifdef INV_MIXCOLUMNS_FWD_MODE_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      IDLE: if (bus_if.i_valid) begin
        state_d = BUSY;
        col_d   = '0;
        work_d  = bus_if.i_state;
`ifdef INV_MIXCOLUMNS_FWD_MODE_EN
        mode_d  = bus_if.i_fwd_mode;
`endif
      end
      BUSY: begin
        work_d[NB_STATE-1-NB_COL*int'(col_q) -: NB_COL] = col_out;
        col_d   = col_q + 2'd1;
        state_d = (col_q == 2'd3) ? DONE : BUSY;
      end
      DONE: state_d = bus_if.i_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decode the state register only; o_state is the working register itself
  assign bus_if.o_ready = (state_q == IDLE);
  assign bus_if.o_valid = (state_q == DONE);
  assign bus_if.o_state = work_q;
endmodule

// File: doc/inv_mixcolumns_iter.md
# inv_mixcolumns_iter

Iterative AES InvMixColumns engine: multiplies each 32-bit column of a 128-bit state by the fixed inverse polynomial {0b}x³+{0d}x²+{09}x+{0e} over GF(2^8) mod x^8+x^4+x^3+x+1 (0x11b). It is the decrypt-side counterpart of the forward MixColumns path and reuses xtime ({02} multiply) chains internally. It sits in the AES decrypt round datapath between InvShiftRows/InvSubBytes and AddRoundKey. It processes one column per clock and uses valid/ready handshakes on both sides.

## Interface
- NB_BYTE, 8, byte width; any other value flags BAD_CONF.
- NB_STATE, 128, state width; must equal 16*NB_BYTE.
- i_clock  input  1  system clock, all logic on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream state valid.
- o_ready  output  1  engine can accept a state.
- i_state  input  NB_STATE  input state. Column c is bits [127-32c -: 32]; row r of a column is [31-8r -: 8] (FIPS-197 byte order, byte 0 at MSB).
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_state  output  NB_STATE  InvMixColumns result, same byte order as i_state.

## Operation
- FSM with 3 states:
  - IDLE: o_ready=1. A transfer happens when i_valid and o_ready are both high. On that edge, capture i_state into a working register, clear col_cnt to 0, and go to BUSY.
  - BUSY: o_ready=0. Each cycle, transform column col_cnt in place and increment col_cnt (2 bits). When col_cnt=3, go to DONE.
  - DONE: o_valid=1 and o_state holds the result. When i_ready is high, go to IDLE on that edge.
- Per-byte math uses a single column datapath (4 bytes), instantiated once:
  - x2=xtime(b), x4=xtime(x2), x8=xtime(x4).
  - 09·b = x8^b.
  - 0b·b = x8^x2^b.
  - 0d·b = x8^x4^b.
  - 0e·b = x8^x4^x2.
- Column output, with row bytes a0..a3 in and r0..r3 out:
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3.
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3.
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3.
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3.
- All arithmetic is XOR only. There is no carry and no width growth; every intermediate is NB_BYTE bits.
- i_valid while not in IDLE is ignored. Upstream must hold the data, since o_ready=0.
- i_ready outside DONE has no effect.
- Reset:
  - Whether idle or mid-operation, reset forces IDLE and col_cnt=0.
  - The working register is cleared to 0. No partial result is ever presented.
  - Output values after reset: o_ready=1, o_valid=0, o_state=0.

## Timing
- Accept at edge N. Columns 0..3 are written at edges N+1..N+4. o_valid rises after edge N+4, giving a latency of 4 cycles from acceptance to o_valid.
- o_state is registered and stable for the whole time o_valid is high, including stalls of any length while i_ready=0.
- With i_ready tied high, DONE lasts 1 cycle, then IDLE lasts ≥1 cycle. Minimum initiation interval is 6 cycles.
- o_ready is a registered function of state only. It has no combinational path from i_ready or i_valid.

## Configuration
- INV_MIXCOLUMNS_FWD_MODE_EN defined:
  - Adds port i_fwd_mode (input, 1 bit), sampled at the accept edge and held for the whole operation.
  - i_fwd_mode=1 selects forward MixColumns coefficients {02,03,01,01}. Per byte, 02·b = x2 and 03·b = x2^b, rotated per row.
  - i_fwd_mode=0 selects InvMixColumns.
  - Latency and handshake are unchanged in both modes.
- INV_MIXCOLUMNS_FWD_MODE_EN not defined: the port is absent and the block performs InvMixColumns only.

## Test plan
- Known vector: i_state columns 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6 give o_state columns db135345, f20a225c, 01010101, d4d4d4d5. o_valid is asserted exactly 4 cycles after the accept.
- Backpressure: hold i_ready=0 for 10 cycles in DONE. o_state stays constant, o_ready stays 0, and new i_valid is ignored. Raise i_ready, then confirm IDLE and o_ready=1 on the next cycle.
- Back-to-back: i_valid held high with two states and i_ready=1. Accepts are exactly 6 cycles apart and both results are correct.
- Reset mid-operation: assert i_reset when col_cnt=2. The next cycle shows o_valid=0, o_ready=1, o_state=0. A following transfer of c6c6c6c6 ×4 returns c6c6c6c6 ×4.
- Round trip (with INV_MIXCOLUMNS_FWD_MODE_EN):
  - fwd_mode=1 on db135345 / f20a225c / c6c6c6c6 / d4d4d4d5 gives 8e4da1bc / 9fdc589d / c6c6c6c6 / d5d5d7d6.
  - Feeding that result back with fwd_mode=0 restores the original input.
- Random: 10k random states checked against a reference model. Inverse of forward must return the identity, with random i_valid/i_ready gaps.
